// File: rtl/trace_cmd_dispatcher.sv
// Routes decoded trace commands to the L1 data/instruction caches and keeps per-class statistics.
// Latency: request outputs rise at the accept edge; each one drops at the edge where its done is sampled.
// Backpressure: cmd_ready is high only when idle; at most one outstanding request per cache.
module trace_cmd_dispatcher #(
    parameter int ADDR_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [OP_WIDTH-1:0]   cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic                  dc_req,
    output logic [OP_WIDTH-1:0]   dc_op,
    output logic [ADDR_WIDTH-1:0] dc_addr,
    input  logic                  dc_done,
    output logic                  ic_req,
    output logic [OP_WIDTH-1:0]   ic_op,
    output logic [ADDR_WIDTH-1:0] ic_addr,
    input  logic                  ic_done,
    output logic                  idle,
    output logic                  bad_cmd,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  if_cnt,
    output logic [CNT_WIDTH-1:0]  snp_cnt
);

    localparam logic [OP_WIDTH-1:0] OP_RD  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_WR  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_IF  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_INV = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_RFO = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_CLR = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_PRT = OP_WIDTH'(9);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DC_WAIT,
        S_IC_WAIT,
        S_BOTH_WAIT,
        S_PRINT_DC,
        S_PRINT_IC
    } state_t;

    state_t                  state, state_n;
    logic                    idle_q, idle_n;
    logic                    dc_req_n, ic_req_n, bad_n;
    logic [OP_WIDTH-1:0]     dc_op_n, ic_op_n;
    logic [ADDR_WIDTH-1:0]   dc_addr_n, ic_addr_n;
    logic [CNT_WIDTH-1:0]    rd_n, wr_n, if_n, snp_n;
    logic                    dc_hit, ic_hit;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // A done only counts while its own request is outstanding.
    assign dc_hit = dc_req && dc_done;
    assign ic_hit = ic_req && ic_done;

    always_comb begin
        state_n   = state;
        dc_req_n  = dc_req;
        ic_req_n  = ic_req;
        dc_op_n   = dc_op;
        ic_op_n   = ic_op;
        dc_addr_n = dc_addr;
        ic_addr_n = ic_addr;
        bad_n     = 1'b0;
        rd_n      = rd_cnt;
        wr_n      = wr_cnt;
        if_n      = if_cnt;
        snp_n     = snp_cnt;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_RD, OP_WR, OP_INV, OP_RFO: begin
                            state_n   = S_DC_WAIT;
                            dc_req_n  = 1'b1;
                            dc_op_n   = cmd_op;
                            dc_addr_n = cmd_addr;
                            if (cmd_op == OP_RD) rd_n = sat_inc(rd_cnt);
                            else if (cmd_op == OP_WR) wr_n = sat_inc(wr_cnt);
                            else snp_n = sat_inc(snp_cnt);
                        end
                        OP_IF: begin
                            state_n   = S_IC_WAIT;
                            ic_req_n  = 1'b1;
                            ic_op_n   = cmd_op;
                            ic_addr_n = cmd_addr;
                            if_n      = sat_inc(if_cnt);
                        end
                        OP_CLR, OP_PRT: begin
                            state_n   = (cmd_op == OP_CLR) ? S_BOTH_WAIT : S_PRINT_DC;
                            dc_req_n  = 1'b1;
                            ic_req_n  = (cmd_op == OP_CLR);
                            dc_op_n   = cmd_op;
                            dc_addr_n = cmd_addr;
                            ic_op_n   = cmd_op;
                            ic_addr_n = cmd_addr;
                            if (cmd_op == OP_CLR) begin
                                rd_n  = '0;
                                wr_n  = '0;
                                if_n  = '0;
                                snp_n = '0;
                            end
                        end
                        default: bad_n = 1'b1;
                    endcase
                end
            end
            S_DC_WAIT: begin
                if (dc_hit) begin
                    dc_req_n = 1'b0;
                    state_n  = S_IDLE;
                end
            end
            S_IC_WAIT: begin
                if (ic_hit) begin
                    ic_req_n = 1'b0;
                    state_n  = S_IDLE;
                end
            end
            S_BOTH_WAIT: begin
                if (dc_hit) dc_req_n = 1'b0;
                if (ic_hit) ic_req_n = 1'b0;
                if ((!dc_req || dc_hit) && (!ic_req || ic_hit)) state_n = S_IDLE;
            end
            S_PRINT_DC: begin
                // Hand over to the icache on the same edge, no bubble.
                if (dc_hit) begin
                    dc_req_n = 1'b0;
                    ic_req_n = 1'b1;
                    state_n  = S_PRINT_IC;
                end
            end
            S_PRINT_IC: begin
                if (ic_hit) begin
                    ic_req_n = 1'b0;
                    state_n  = S_IDLE;
                end
            end
            default: begin
                state_n  = S_IDLE;
                dc_req_n = 1'b0;
                ic_req_n = 1'b0;
            end
        endcase
        idle_n = (state_n == S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            idle_q  <= 1'b1;
            dc_req  <= 1'b0;
            ic_req  <= 1'b0;
            dc_op   <= '0;
            ic_op   <= '0;
            dc_addr <= '0;
            ic_addr <= '0;
            bad_cmd <= 1'b0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            if_cnt  <= '0;
            snp_cnt <= '0;
        end else begin
            state   <= state_n;
            idle_q  <= idle_n;
            dc_req  <= dc_req_n;
            ic_req  <= ic_req_n;
            dc_op   <= dc_op_n;
            ic_op   <= ic_op_n;
            dc_addr <= dc_addr_n;
            ic_addr <= ic_addr_n;
            bad_cmd <= bad_n;
            rd_cnt  <= rd_n;
            wr_cnt  <= wr_n;
            if_cnt  <= if_n;
            snp_cnt <= snp_n;
        end
    end

    assign cmd_ready = idle_q;
    assign idle      = idle_q;

endmodule
